// File: rtl/cosmic_ce_pkg.sv
// ============================================================================
// cosmic_ce_pkg : shared types, standard rates and game-ID divisor lookup
// Rev 1.0
// ============================================================================
`default_nettype none

package cosmic_ce_pkg;

  typedef enum logic {
    CE_INT  = 1'b0,
    CE_FRAC = 1'b1
  } ce_mode_e;

  localparam int CE_VAL_W = 16;

  // Divisor values for the standard rates derived from a 10.816 MHz clk_sys
  localparam logic [CE_VAL_W-1:0] CE_DIV_PIX = 16'd1;
  localparam logic [CE_VAL_W-1:0] CE_DIV_2M7 = 16'd3;
  localparam logic [CE_VAL_W-1:0] CE_DIV_1M8 = 16'd5;

  function automatic logic [CE_VAL_W-1:0] cpu_div(input logic [7:0] game_id);
    if (game_id == 8'd2 || game_id == 8'd4) return CE_DIV_2M7;
    return CE_DIV_1M8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ce_chan.sv
// ============================================================================
// ce_chan : one enable channel, integer divider or fractional accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module ce_chan
  import cosmic_ce_pkg::*;
#(
  parameter int                 VAL_W    = 16,
  parameter logic               DEF_MODE = 1'b0,
  parameter logic [VAL_W-1:0]   DEF_VAL  = '0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             wr,
  input  logic             wr_mode,
  input  logic [VAL_W-1:0] wr_val,
  input  logic             resync,
  input  logic             freeze,
  output logic             pulse_nxt,
  output logic             ce_raw
);

  ce_mode_e         mode;
  logic [VAL_W-1:0] val;
  logic [VAL_W-1:0] cnt;
  logic [VAL_W-1:0] cnt_nxt;
  logic [VAL_W:0]   sum;

  always_comb begin
    sum       = {1'b0, cnt} + {1'b0, val};
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;
    // A write or resync restarts the phase and swallows any pending pulse
    if (wr || resync) begin
      cnt_nxt = '0;
    end else if (!freeze) begin
      if (mode == CE_FRAC) begin
        cnt_nxt   = sum[VAL_W-1:0];
        pulse_nxt = sum[VAL_W];
      end else if (cnt == val) begin
        cnt_nxt   = '0;
        pulse_nxt = 1'b1;
      end else begin
        cnt_nxt = cnt + VAL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      mode   <= ce_mode_e'(DEF_MODE);
      val    <= DEF_VAL;
      cnt    <= '0;
      ce_raw <= 1'b0;
    end else begin
      if (wr) begin
        mode <= ce_mode_e'(wr_mode);
        val  <= wr_val;
      end
      cnt    <= cnt_nxt;
      ce_raw <= pulse_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ce_gen_multi.sv
// ============================================================================
// ce_gen_multi : multi-channel clock-enable generator with pause gating
// Rev 1.0
// ============================================================================
`default_nettype none

module ce_gen_multi
  import cosmic_ce_pkg::*;
#(
  parameter int                          NUM_CH     = 4,
  parameter int                          VAL_W      = 16,
  parameter logic [NUM_CH-1:0]           DEF_MODE   = 4'b0000,
  parameter logic [NUM_CH*VAL_W-1:0]     DEF_VAL    = {16'd5, 16'd3, 16'd1, 16'd0},
  parameter logic [NUM_CH-1:0]           PAUSE_MASK = 4'b1100,
  localparam int                         CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic              cfg_mode,
  input  logic [VAL_W-1:0]  cfg_val,
  input  logic              resync,
  input  logic              pause,
  output logic [NUM_CH-1:0] ce_out,
  output logic [NUM_CH-1:0] ce_raw,
  output logic [7:0]        ce_cnt0
);

  logic [NUM_CH-1:0] pulse_nxt;
  logic [NUM_CH-1:0] freeze;

  assign freeze = {NUM_CH{pause}} & PAUSE_MASK;

  // Out-of-range cfg_ch values match no channel and are therefore ignored
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = cfg_wr && (cfg_ch == CH_W'(i));

    ce_chan #(
      .VAL_W    (VAL_W),
      .DEF_MODE (DEF_MODE[i]),
      .DEF_VAL  (DEF_VAL[i*VAL_W +: VAL_W])
    ) u_chan (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .wr        (wr_sel),
      .wr_mode   (cfg_mode),
      .wr_val    (cfg_val),
      .resync    (resync),
      .freeze    (freeze[i]),
      .pulse_nxt (pulse_nxt[i]),
      .ce_raw    (ce_raw[i])
    );
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      ce_out  <= '0;
      ce_cnt0 <= '0;
    end else begin
      ce_out <= pulse_nxt & ~freeze;
      if (ce_out[0]) ce_cnt0 <= ce_cnt0 + 8'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ce_gen_multi.sv
// Testbench for ce_gen_multi: directed scenarios plus randomized traffic
// checked against a cycle-count based reference model.
`default_nettype none

module tb_ce_gen_multi;

  localparam int                NUM_CH     = 4;
  localparam int                VAL_W      = 16;
  localparam logic [3:0]        DEF_MODE   = 4'b0000;
  localparam logic [63:0]       DEF_VAL    = {16'd5, 16'd3, 16'd1, 16'd0};
  localparam logic [3:0]        PAUSE_MASK = 4'b1100;

  logic             clk_sys = 1'b0;
  logic             reset   = 1'b1;
  logic             cfg_wr  = 1'b0;
  logic [1:0]       cfg_ch  = '0;
  logic             cfg_mode = 1'b0;
  logic [VAL_W-1:0] cfg_val = '0;
  logic             resync  = 1'b0;
  logic             pause   = 1'b0;
  logic [3:0]       ce_out;
  logic [3:0]       ce_raw;
  logic [7:0]       ce_cnt0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: each channel tracks how many running cycles have elapsed
  // since its phase was last cleared; pulses follow directly from that count.
  logic             m_mode [NUM_CH];
  logic [VAL_W-1:0] m_val  [NUM_CH];
  longint unsigned  m_n    [NUM_CH];
  logic [3:0]       m_raw  = '0;
  logic [3:0]       m_out  = '0;
  logic [7:0]       m_cnt0 = '0;

  ce_gen_multi #(
    .NUM_CH     (NUM_CH),
    .VAL_W      (VAL_W),
    .DEF_MODE   (DEF_MODE),
    .DEF_VAL    (DEF_VAL),
    .PAUSE_MASK (PAUSE_MASK)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .cfg_wr   (cfg_wr),
    .cfg_ch   (cfg_ch),
    .cfg_mode (cfg_mode),
    .cfg_val  (cfg_val),
    .resync   (resync),
    .pause    (pause),
    .ce_out   (ce_out),
    .ce_raw   (ce_raw),
    .ce_cnt0  (ce_cnt0)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic bit fire(input bit mode, input longint unsigned v, input longint unsigned n);
    if (n == 0) return 1'b0;
    if (!mode) return (n % (v + 1)) == 0;
    return ((n * v) >> VAL_W) != (((n - 1) * v) >> VAL_W);
  endfunction

  task automatic model_step();
    if (reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_mode[c] = DEF_MODE[c];
        m_val[c]  = DEF_VAL[c*VAL_W +: VAL_W];
        m_n[c]    = 0;
      end
      m_raw  = '0;
      m_out  = '0;
      m_cnt0 = '0;
    end else begin
      m_cnt0 = m_cnt0 + {7'd0, m_out[0]};
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_wr && cfg_ch == c[1:0]) begin
          m_mode[c] = cfg_mode;
          m_val[c]  = cfg_val;
        end
        if ((cfg_wr && cfg_ch == c[1:0]) || resync) begin
          m_n[c]   = 0;
          m_raw[c] = 1'b0;
        end else if (pause && PAUSE_MASK[c]) begin
          m_raw[c] = 1'b0;
        end else begin
          m_n[c]   = m_n[c] + 1;
          m_raw[c] = fire(m_mode[c], m_val[c], m_n[c]);
        end
      end
      m_out = m_raw & ~({4{pause}} & PAUSE_MASK);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; cfg_wr = 1'b0; resync = 1'b0; pause = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ce_out, ce_raw, ce_cnt0} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: out=%b raw=%b cnt0=%0d, expected all zero", ce_out, ce_raw, ce_cnt0);
    end
    idle_inputs();
    for (int c = 1; c <= 24; c++) begin
      logic [3:0] exp_raw;
      tick();
      exp_raw = {c % 6 == 0, c % 4 == 0, c % 2 == 0, 1'b1};
      n_checks++;
      if (ce_raw !== exp_raw || ce_out !== exp_raw) begin
        n_fail++;
        $display("FAIL default_rates cyc %0d: raw=%b out=%b, expected %b", c, ce_raw, ce_out, exp_raw);
      end
    end
    n_checks++;
    if (ce_cnt0 !== 8'd23) begin
      n_fail++;
      $display("FAIL cnt0_after_24: got %0d, expected 23", ce_cnt0);
    end
  endtask

  task automatic test_frac();
    int pulses, last, sum_pulses;
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_mode = 1'b1; cfg_val = 16'h4000;
    tick();
    cfg_wr = 1'b0;
    pulses = 0; last = -1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      if (ce_raw[2]) begin
        if (last >= 0) begin
          n_checks++;
          if (c - last != 4) begin
            n_fail++;
            $display("FAIL frac_4000_gap cyc %0d: gap %0d, expected 4", c, c - last);
          end
        end
        last = c;
        pulses++;
      end
    end
    n_checks++;
    if (pulses != 16) begin
      n_fail++;
      $display("FAIL frac_4000_count: got %0d pulses, expected 16", pulses);
    end
    cfg_wr = 1'b1; cfg_val = 16'h5555;
    tick();
    cfg_wr = 1'b0;
    sum_pulses = 0;
    for (int c = 1; c <= 3 * 16384; c++) begin
      tick();
      sum_pulses += int'(ce_raw[2]);
      n_checks++;
      if ({ce_out, ce_raw, ce_cnt0} !== {m_out, m_raw, m_cnt0}) begin
        n_fail++;
        $display("FAIL frac_5555_model cyc %0d: out=%b raw=%b cnt0=%0d, expected out=%b raw=%b cnt0=%0d",
                 c, ce_out, ce_raw, ce_cnt0, m_out, m_raw, m_cnt0);
      end
    end
    n_checks++;
    if (sum_pulses < 16382 || sum_pulses > 16384) begin
      n_fail++;
      $display("FAIL frac_5555_count: got %0d pulses, expected 16383 +-1", sum_pulses);
    end
  endtask

  task automatic test_mid_write();
    reset = 1'b1; tick(); idle_inputs();
    for (int c = 0; c < 3; c++) tick();
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_mode = 1'b0; cfg_val = 16'd3;
    tick();
    cfg_wr = 1'b0;
    n_checks++;
    if (ce_raw[3] !== 1'b0 || ce_out[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_write_suppress: raw3=%b out3=%b, expected 0", ce_raw[3], ce_out[3]);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (ce_raw[3] !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL mid_write_period k=%0d: raw3=%b, expected %b", k, ce_raw[3], k % 4 == 0);
      end
    end
  endtask

  task automatic test_pause();
    reset = 1'b1; tick(); idle_inputs();
    tick(); tick();
    pause = 1'b1;
    for (int c = 3; c <= 12; c++) begin
      tick();
      n_checks++;
      if (ce_raw[3] !== 1'b0 || ce_out[3] !== 1'b0 || ce_out[0] !== 1'b1 || ce_out[1] !== (c % 2 == 0)) begin
        n_fail++;
        $display("FAIL pause_hold cyc %0d: raw=%b out=%b, expected ch3 silent, ch0=1, ch1=%b",
                 c, ce_raw, ce_out, c % 2 == 0);
      end
    end
    pause = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_checks++;
      if (ce_raw[3] !== (k == 4) || ce_out[3] !== (k == 4)) begin
        n_fail++;
        $display("FAIL pause_resume k=%0d: raw3=%b out3=%b, expected %b", k, ce_raw[3], ce_out[3], k == 4);
      end
    end
  endtask

  task automatic test_resync_write();
    reset = 1'b1; tick(); idle_inputs();
    for (int c = 0; c < 7; c++) tick();
    resync = 1'b1; cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_mode = 1'b0; cfg_val = 16'd2;
    tick();
    resync = 1'b0; cfg_wr = 1'b0;
    n_checks++;
    if (ce_raw !== 4'd0 || ce_out !== 4'd0) begin
      n_fail++;
      $display("FAIL resync_silent: raw=%b out=%b, expected 0000", ce_raw, ce_out);
    end
    for (int k = 1; k <= 12; k++) begin
      tick();
      n_checks++;
      if (ce_raw[1] !== (k % 3 == 0) || ce_raw[3] !== (k % 6 == 0) || ce_raw[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL resync_align k=%0d: raw=%b, expected ch1=%b ch3=%b ch0=1",
                 k, ce_raw, k % 3 == 0, k % 6 == 0);
      end
    end
  endtask

  task automatic test_reset_pause();
    reset = 1'b1; tick(); idle_inputs();
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_mode = 1'b1; cfg_val = 16'h4000;
    tick();
    cfg_wr = 1'b0;
    for (int c = 0; c < 5; c++) tick();
    pause = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    reset = 1'b1;
    tick();
    n_checks++;
    if ({ce_out, ce_raw, ce_cnt0} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_in_pause: out=%b raw=%b cnt0=%0d, expected all zero", ce_out, ce_raw, ce_cnt0);
    end
    idle_inputs();
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_checks++;
      if (ce_raw[2] !== (k % 4 == 0)) begin
        n_fail++;
        $display("FAIL reset_restores_ch2 k=%0d: raw2=%b, expected %b", k, ce_raw[2], k % 4 == 0);
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      reset    = ($urandom_range(0, 199) == 0);
      cfg_wr   = ($urandom_range(0, 7) == 0);
      cfg_ch   = 2'($urandom_range(0, 3));
      cfg_mode = 1'($urandom_range(0, 1));
      cfg_val  = cfg_mode ? 16'($urandom) : 16'($urandom_range(0, 9));
      resync   = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 19) == 0) pause = ~pause;
      tick();
      n_checks++;
      if ({ce_out, ce_raw, ce_cnt0} !== {m_out, m_raw, m_cnt0}) begin
        n_fail++;
        $display("FAIL random_model cyc %0d: out=%b raw=%b cnt0=%0d, expected out=%b raw=%b cnt0=%0d",
                 c, ce_out, ce_raw, ce_cnt0, m_out, m_raw, m_cnt0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #2;
    test_reset();
    test_frac();
    test_mid_write();
    test_pause();
    test_resync_write();
    test_reset_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
